// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared definitions for the parametrised APB3 master:
//                FSM state encoding, default widths/limits and response
//                flag constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    // APB transfer phases; 2'b11 is unused and decodes back to IDLE
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } apb_state_e;

    // Default configuration
    localparam int C_APB_ADDR_W  = 32;
    localparam int C_APB_DATA_W  = 32;
    localparam int C_APB_TIMEOUT = 16;

    // Response flag values
    localparam logic C_RSP_OK         = 1'b0;
    localparam logic C_RSP_ERR        = 1'b1;
    localparam logic C_RSP_NO_TIMEOUT = 1'b0;
    localparam logic C_RSP_TIMEOUT    = 1'b1;

    // Counter width able to hold values 0..limit inclusive
    function automatic int wait_cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : apb_wait_timer
//  Description : Counts ACCESS cycles spent with P_ready low and flags the
//                cycle in which the count reaches TIMEOUT. Only instantiated
//                by apb_master_param when APB_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = C_APB_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,   // SETUP phase: restart the count
    input  logic i_wait,    // ACCESS phase with P_ready low
    output logic o_expire   // this wait cycle brings the count to TIMEOUT
);

    localparam int                CNT_W   = wait_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0]  C_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  C_LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear on SETUP, increment per wait cycle, saturate at limit
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_wait && (count_q != C_LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is flagged during the wait cycle whose increment reaches the
    // limit, so the master leaves ACCESS after exactly TIMEOUT wait cycles.
    assign o_expire = i_wait && (count_q == C_LAST);

endmodule : apb_wait_timer
`default_nettype wire

// File: rtl/apb_master_param.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_param
//  Description : Parametrised APB3 master. Takes read/write commands over a
//                valid/ready handshake, runs them through IDLE/SETUP/ACCESS,
//                honours P_ready wait states, reports P_slverr and chains
//                back-to-back transfers without an IDLE gap.
//                Optional feature macro: APB_TIMEOUT_EN (abort an ACCESS
//                phase after TIMEOUT wait cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_param
    import apb_pkg::*;
#(
    parameter int ADDR_W  = C_APB_ADDR_W,
    parameter int DATA_W  = C_APB_DATA_W,
    parameter int TIMEOUT = C_APB_TIMEOUT
) (
    input  logic              Pclk,
    input  logic              Prst,
    // Requester command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // Requester response channel
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    // APB bus
    output logic [ADDR_W-1:0] Paddr,
    output logic              PSELx,
    output logic              P_en,
    output logic              P_WR,
    output logic [DATA_W-1:0] PWdata,
    input  logic [DATA_W-1:0] PRdata,
    input  logic              P_ready,
    input  logic              P_slverr
);

    // Elaboration-time parameter sanity checks
    if (!((DATA_W == 8) || (DATA_W == 16) || (DATA_W == 32))) begin : g_bad_data_w
        $error("apb_master_param: DATA_W must be 8, 16 or 32");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("apb_master_param: TIMEOUT must be at least 2");
    end

    apb_state_e         state_q;
    apb_state_e         state_d;
    logic [ADDR_W-1:0]  paddr_q;
    logic [ADDR_W-1:0]  paddr_d;
    logic               pwrite_q;
    logic               pwrite_d;
    logic [DATA_W-1:0]  pwdata_q;
    logic [DATA_W-1:0]  pwdata_d;
    logic               rsp_valid_q;
    logic               rsp_valid_d;
    logic               rsp_err_q;
    logic               rsp_err_d;
    logic [DATA_W-1:0]  rsp_rdata_q;
    logic [DATA_W-1:0]  rsp_rdata_d;

    logic               wait_clear;
    logic               wait_cycle;

    assign wait_clear = (state_q == ST_SETUP);
    assign wait_cycle = (state_q == ST_ACCESS) && !P_ready;

`ifdef APB_TIMEOUT_EN
    logic               wait_expire;
    logic               rsp_timeout_q;
    logic               rsp_timeout_d;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (Pclk),
        .rst_n    (Prst),
        .i_clear  (wait_clear),
        .i_wait   (wait_cycle),
        .o_expire (wait_expire)
    );

    assign rsp_timeout = rsp_timeout_q;
`else
    // Without the timer the master waits indefinitely; the wait decode is
    // kept only as a named debug point.
    logic unused_wait;
    assign unused_wait = wait_clear ^ wait_cycle;
    assign rsp_timeout = C_RSP_NO_TIMEOUT;
`endif

    // Next-state, command capture and response generation
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = C_RSP_OK;
        rsp_rdata_d = rsp_rdata_q;
        cmd_ready   = 1'b0;
`ifdef APB_TIMEOUT_EN
        rsp_timeout_d = C_RSP_NO_TIMEOUT;
`endif

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    if (cmd_write) begin
                        pwdata_d = cmd_wdata;
                    end
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                state_d = ST_ACCESS;
            end

            ST_ACCESS: begin
                // The only combinational input-to-output path of the block
                cmd_ready = P_ready;
                if (P_ready) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = P_slverr ? C_RSP_ERR : C_RSP_OK;
                    if (!pwrite_q) begin
                        rsp_rdata_d = PRdata;
                    end
                    if (cmd_valid) begin
                        // Chain straight into the next SETUP, PSELx stays high
                        paddr_d  = cmd_addr;
                        pwrite_d = cmd_write;
                        if (cmd_write) begin
                            pwdata_d = cmd_wdata;
                        end
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                end else if (wait_expire) begin
                    // Abort: drop the bus, read data left untouched
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = C_RSP_ERR;
                    rsp_timeout_d = C_RSP_TIMEOUT;
                    state_d       = ST_IDLE;
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, bus and response registers
    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= C_RSP_OK;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    // Timeout response flag register
    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) begin
            rsp_timeout_q <= C_RSP_NO_TIMEOUT;
        end else begin
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
`endif

    // Bus outputs are state-decoded or registered
    assign PSELx     = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign P_en      = (state_q == ST_ACCESS);
    assign Paddr     = paddr_q;
    assign P_WR      = pwrite_q;
    assign PWdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule : apb_master_param
`default_nettype wire

// File: tb/tb_apb_master_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_param
//  Description : Directed self-checking bench for apb_master_param.
//                Timeout scenario is included when APB_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_param;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              Pclk = 1'b0;
    logic              Prst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic [ADDR_W-1:0] Paddr;
    logic              PSELx;
    logic              P_en;
    logic              P_WR;
    logic [DATA_W-1:0] PWdata;
    logic [DATA_W-1:0] PRdata;
    logic              P_ready;
    logic              P_slverr;

    int n_checks = 0;
    int n_errors = 0;

    // Bench-side memory of what the bus/response registers should hold
    logic [DATA_W-1:0] last_wd;
    logic [DATA_W-1:0] last_rd;

    apb_master_param #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Pclk        (Pclk),
        .Prst        (Prst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .Paddr       (Paddr),
        .PSELx       (PSELx),
        .P_en        (P_en),
        .P_WR        (P_WR),
        .PWdata      (PWdata),
        .PRdata      (PRdata),
        .P_ready     (P_ready),
        .P_slverr    (P_slverr)
    );

    always #5 Pclk = ~Pclk;

    // Single comparison point
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge Pclk);
        #1;
    endtask

    // One isolated transfer with a given number of wait cycles
    task automatic run_xfer(input logic wr, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input int waits,
                            input logic [DATA_W-1:0] rdata, input logic err);
        logic [DATA_W-1:0] exp_wd;
        logic [DATA_W-1:0] exp_rd;
        exp_wd = wr ? wdata : last_wd;
        exp_rd = wr ? last_rd : rdata;

        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        P_ready = 1'b0; P_slverr = 1'b0;
        #1;
        check_eq("idle_cmd_ready", cmd_ready, 1'b1);
        tick();                                   // cycle N+1: SETUP
        cmd_valid = 1'b0; cmd_wdata = ~wdata; cmd_addr = ~addr;
        #1;
        check_eq("setup_psel",   PSELx, 1'b1);
        check_eq("setup_pen",    P_en, 1'b0);
        check_eq("setup_ready",  cmd_ready, 1'b0);
        check_eq("setup_paddr",  Paddr, addr);
        check_eq("setup_pwr",    P_WR, wr);
        check_eq("setup_pwdata", PWdata, exp_wd);
        for (int i = 0; i <= waits; i++) begin
            tick();                               // ACCESS cycle i
            if (i == waits) begin
                P_ready = 1'b1; P_slverr = err; PRdata = rdata;
            end else begin
                P_ready = 1'b0; P_slverr = 1'b1; PRdata = '1;
            end
            #1;
            check_eq("acc_psel",   PSELx, 1'b1);
            check_eq("acc_pen",    P_en, 1'b1);
            check_eq("acc_paddr",  Paddr, addr);
            check_eq("acc_pwdata", PWdata, exp_wd);
            check_eq("acc_ready",  cmd_ready, (i == waits));
            check_eq("acc_rspv",   rsp_valid, 1'b0);
        end
        tick();                                   // response cycle
        P_ready = 1'b0; P_slverr = 1'b0; PRdata = 32'h5555_AAAA;
        check_eq("rsp_valid",   rsp_valid, 1'b1);
        check_eq("rsp_err",     rsp_err, err);
        check_eq("rsp_timeout", rsp_timeout, 1'b0);
        check_eq("rsp_rdata",   rsp_rdata, exp_rd);
        check_eq("rsp_psel",    PSELx, 1'b0);
        last_wd = exp_wd;
        last_rd = exp_rd;
        tick();
        check_eq("rsp_pulse_end", rsp_valid, 1'b0);
        check_eq("rsp_rdata_hold", rsp_rdata, exp_rd);
        check_eq("idle_paddr_hold", Paddr, addr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        Prst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; PRdata = '0; P_ready = 1'b0; P_slverr = 1'b0;
        last_wd = '0; last_rd = '0;

        // Reset state
        #3;
        check_eq("rst_psel",      PSELx, 1'b0);
        check_eq("rst_pen",       P_en, 1'b0);
        check_eq("rst_paddr",     Paddr, 32'h0);
        check_eq("rst_pwdata",    PWdata, 32'h0);
        check_eq("rst_pwr",       P_WR, 1'b0);
        check_eq("rst_cmd_ready", cmd_ready, 1'b1);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_rdata",     rsp_rdata, 32'h0);
        tick(); tick();
        Prst = 1'b1;
        tick(); tick();
        check_eq("rel_psel",  PSELx, 1'b0);
        check_eq("rel_rspv",  rsp_valid, 1'b0);
        check_eq("rel_ready", cmd_ready, 1'b1);

        // Zero-wait write, then a read with 3 wait cycles
        run_xfer(1'b1, 32'h0000_A000, 32'h0000_1234, 0, 32'h0, 1'b0);
        run_xfer(1'b0, 32'h0000_A004, 32'h0,         3, 32'hDEAD_BEEF, 1'b0);

        // Slave error, then a clean follow-up transfer
        run_xfer(1'b1, 32'h0000_C000, 32'h0000_0001, 0, 32'h0, 1'b1);
        run_xfer(1'b0, 32'h0000_C004, 32'h0,         1, 32'h1234_5678, 1'b0);

        // Back-to-back: write then read with cmd_valid held
        P_ready = 1'b1; P_slverr = 1'b0; PRdata = 32'h0BAD_F00D;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_B000; cmd_wdata = 32'h0000_CAFE;
        tick();                                   // SETUP #1
        cmd_write = 1'b0; cmd_addr = 32'h0000_B004; cmd_wdata = 32'h0000_0BAD;
        #1;
        check_eq("b2b_s1_psel",  PSELx, 1'b1);
        check_eq("b2b_s1_ready", cmd_ready, 1'b0);
        check_eq("b2b_s1_pwr",   P_WR, 1'b1);
        tick();                                   // ACCESS #1, read accepted here
        check_eq("b2b_a1_pen",   P_en, 1'b1);
        check_eq("b2b_a1_ready", cmd_ready, 1'b1);
        check_eq("b2b_a1_paddr", Paddr, 32'h0000_B000);
        tick();                                   // SETUP #2 + write response
        cmd_valid = 1'b0;
        #1;
        check_eq("b2b_s2_psel",   PSELx, 1'b1);
        check_eq("b2b_s2_pen",    P_en, 1'b0);
        check_eq("b2b_s2_paddr",  Paddr, 32'h0000_B004);
        check_eq("b2b_s2_pwr",    P_WR, 1'b0);
        check_eq("b2b_s2_pwdata", PWdata, 32'h0000_CAFE);
        check_eq("b2b_rsp1",      rsp_valid, 1'b1);
        check_eq("b2b_rsp1_rd",   rsp_rdata, last_rd);
        tick();                                   // ACCESS #2
        check_eq("b2b_a2_pen",  P_en, 1'b1);
        check_eq("b2b_a2_rspv", rsp_valid, 1'b0);
        tick();                                   // read response
        check_eq("b2b_rsp2",    rsp_valid, 1'b1);
        check_eq("b2b_rsp2_rd", rsp_rdata, 32'h0BAD_F00D);
        check_eq("b2b_end_psel", PSELx, 1'b0);
        last_wd = 32'h0000_CAFE;
        last_rd = 32'h0BAD_F00D;
        P_ready = 1'b0;
        tick();
        check_eq("b2b_end_rspv", rsp_valid, 1'b0);

`ifdef APB_TIMEOUT_EN
        // Timeout: P_ready held low, abort after TIMEOUT ACCESS cycles
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_D000;
        tick();                                   // SETUP
        cmd_valid = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
            check_eq("tmo_acc_pen",  P_en, 1'b1);
            check_eq("tmo_acc_rspv", rsp_valid, 1'b0);
        end
        tick();
        check_eq("tmo_rspv",  rsp_valid, 1'b1);
        check_eq("tmo_err",   rsp_err, 1'b1);
        check_eq("tmo_flag",  rsp_timeout, 1'b1);
        check_eq("tmo_rdata", rsp_rdata, last_rd);
        check_eq("tmo_psel",  PSELx, 1'b0);
        check_eq("tmo_pen",   P_en, 1'b0);
        tick();
        check_eq("tmo_pulse_end", rsp_valid, 1'b0);
        check_eq("tmo_flag_end",  rsp_timeout, 1'b0);
`endif

        // Reset asserted mid-ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_E000; cmd_wdata = 32'h0000_7777;
        P_ready = 1'b0;
        tick();                                   // SETUP
        cmd_valid = 1'b0;
        tick();                                   // ACCESS
        check_eq("mid_pen", P_en, 1'b1);
        Prst = 1'b0;
        #1;
        check_eq("mid_rst_psel",   PSELx, 1'b0);
        check_eq("mid_rst_pen",    P_en, 1'b0);
        check_eq("mid_rst_paddr",  Paddr, 32'h0);
        check_eq("mid_rst_pwdata", PWdata, 32'h0);
        check_eq("mid_rst_ready",  cmd_ready, 1'b1);
        check_eq("mid_rst_rdata",  rsp_rdata, 32'h0);
        tick();
        Prst = 1'b1; P_ready = 1'b1;
        tick();
        check_eq("mid_no_rsp1", rsp_valid, 1'b0);
        tick();
        check_eq("mid_no_rsp2", rsp_valid, 1'b0);
        check_eq("mid_idle",    PSELx, 1'b0);
        last_wd = '0;
        last_rd = '0;

        // Normal operation after reset recovery
        run_xfer(1'b0, 32'h0000_F000, 32'h0, 2, 32'hA5A5_0F0F, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_apb_master_param
`default_nettype wire
